// File: rtl/video_modulator_phase_seq.sv
// video_modulator_phase_seq: subcarrier phase accumulator sequencing sin/cos lookups through one shared LUT
module video_modulator_phase_seq #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             acc_clear,
  input  logic             line_start,
  input  logic             pal_mode,
  input  logic [ACC_W-1:0] phase_inc,
  output logic [8:0]       lut_phase,
  input  logic [7:0]       lut_value,
  output logic [7:0]       sin_out,
  output logic [7:0]       cos_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);
  typedef enum logic [1:0] {IDLE, REQ_SIN, REQ_COS, CAP_COS} state_t;
  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_base;
  logic [8:0]       p;
  logic             parity, par_eff, par, accept;
  // next state plus the clear/parity values that take effect in this same cycle
  always_comb begin
    acc_base = acc_clear ? '0 : acc;
    par_eff  = parity ^ line_start;
    busy     = state != IDLE;
    accept   = !busy && en;
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = en ? REQ_SIN : IDLE;
      REQ_SIN: state_nx = REQ_COS;
      REQ_COS: state_nx = CAP_COS;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // accumulator, line parity, LUT addressing and sample capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= '0;
      parity    <= 1'b0;
      par       <= 1'b0;
      p         <= '0;
      lut_phase <= '0;
      sin_out   <= '0;
      cos_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      acc       <= accept ? acc_base + phase_inc : acc_base;
      parity    <= par_eff;
      overrun   <= overrun | (en & busy);
      out_valid <= state == CAP_COS;
      if (accept) begin
        p   <= acc_base[ACC_W-1 -: 9];
        par <= par_eff;
      end
      if (state == REQ_SIN) lut_phase <= p;
      if (state == REQ_COS) begin
        sin_out   <= lut_value;
        lut_phase <= p + 9'd128;
      end
      if (state == CAP_COS) cos_out <= (pal_mode & par) ? 8'd0 - lut_value : lut_value;
    end
endmodule

// File: doc/video_modulator_phase_seq.md
VIDEO_MODULATOR_PHASE_SEQ -- requirements
Module: video_modulator_phase_seq

Interface
REQ-001 Parameter: ACC_W, default 24, width of the subcarrier phase accumulator; LUT phase is acc[ACC_W-1:ACC_W-9].
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  sample strobe; requests one sin/cos pair and one accumulator advance.
REQ-005 acc_clear  input  1  synchronous frame-start clear of the accumulator.
REQ-006 line_start  input  1  one-cycle pulse at each line start; toggles line parity.
REQ-007 pal_mode  input  1  1 = negate cos output on odd-parity lines; 0 = never negate.
REQ-008 phase_inc  input  ACC_W  accumulator increment per accepted en.
REQ-009 lut_phase  output  9  registered phase to the shared sine LUT.
REQ-010 lut_value  input  8  LUT result, two's complement, valid one cycle after lut_phase is presented.
REQ-011 sin_out  output  8  captured sine sample.
REQ-012 cos_out  output  8  captured cosine sample, PAL-negated when required.
REQ-013 out_valid  output  1  one-cycle pulse; sin_out and cos_out are new and stable.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.
REQ-015 overrun  output  1  sticky; set when en arrives while busy.

Function
REQ-016 FSM states SHALL be IDLE, REQ_SIN, REQ_COS and CAP_COS.
REQ-017 IDLE with en=1 SHALL accept the request: p <= acc top 9 bits (pre-increment), par <= parity effective this cycle, acc <= acc + phase_inc mod 2^ACC_W, next state REQ_SIN.
REQ-018 REQ_SIN SHALL drive lut_phase = p; next state REQ_COS.
REQ-019 REQ_COS SHALL capture lut_value into sin_out, drive lut_phase = (p + 128) mod 512; next state CAP_COS.
REQ-020 CAP_COS SHALL capture cos_out = (pal_mode & par) ? (0 - lut_value) mod 256 : lut_value, assert out_valid on the following cycle, and return to IDLE.
REQ-021 Latency SHALL be fixed: en accepted at edge N -> out_valid high in cycle N+4; maximum throughput is one pair per 4 cycles.
REQ-022 sin_out and cos_out SHALL hold their values between out_valid pulses.
REQ-023 en while busy=1 SHALL be ignored (no acc advance) and SHALL set overrun; overrun clears only on reset.
REQ-024 en in the cycle out_valid is high (FSM IDLE) SHALL be accepted normally.
REQ-025 acc_clear SHALL set acc to 0; if en is accepted in the same cycle, p = 0 and acc <= phase_inc.
REQ-026 line_start SHALL toggle parity; if line_start and en coincide, the toggled parity SHALL apply to that request.
REQ-027 acc_clear and line_start SHALL act regardless of FSM state and SHALL not disturb an in-flight request.
REQ-028 lut_phase SHALL hold its last value in IDLE and CAP_COS.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, acc 0, parity 0, p 0, lut_phase 0, sin_out 0, cos_out 0, out_valid 0, busy 0, overrun 0.
REQ-030 Reset asserted mid-request SHALL abort it; no out_valid SHALL follow reset release until a new en is accepted.

Verification
REQ-031 phase_inc=0x008000, en at cycles 0 and 4 -> out_valid at 4 (sin 0, cos 100) and at 8 (sin 1, cos 100).
REQ-032 pal_mode=1, one line_start, phase 0 -> cos_out 156 (-100), sin_out 0; pal_mode=0 -> cos_out 100.
REQ-033 acc=0xFF8000 (p=511), phase_inc=0x008000 -> sin_out 255, cos_out 100 (phase 127); next request p=0.
REQ-034 en held high for 8 cycles -> exactly 2 out_valid pulses, acc advanced twice, overrun=1.
REQ-035 rst_n low during REQ_COS -> all outputs 0 at once, no out_valid after release; acc_clear with en -> sin_out 0, next p = phase_inc top bits.
